// File: rtl/lf_adder_share_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lf_adder_share_arb (with helper Ladner_Fischer_Exact)        |
// | Description : Round-robin arbiter that shares one exact 16-bit Ladner-     |
// |               Fischer prefix adder among NREQ requesters. It supports      |
// |               locked multi-word carry chains and a single-entry result     |
// |               buffer with valid/ready handshaking.                         |
// | Options     : `define LF_ARB_STATS_EN adds per-requester grant counters    |
// |               and the stat_sel / stat_count ports.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

// Exact 16-bit Ladner-Fischer prefix adder. The carry-in is folded into bit 0's
// generate term. Bit 16 of the result is the carry-out.
module Ladner_Fischer_Exact (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [16:0] sum_o
);
    // Prefix tree: at level l, each bit with bit l of its index set absorbs the
    // group (G,P) of the last bit of the preceding 2^l-aligned half block.
    always_comb begin
        logic [15:0] g0;
        logic [15:0] p0;
        logic [15:0] gg;
        logic [15:0] pp;
        logic [15:0] gn;
        logic [15:0] pn;
        int          j;
        g0    = a_i & b_i;
        p0    = a_i ^ b_i;
        gg    = g0;
        gg[0] = g0[0] | (p0[0] & cin_i);
        pp    = p0;
        gn    = gg;
        pn    = pp;
        j     = 0;
        for (int l = 0; l < 4; l++) begin
            gn = gg;
            pn = pp;
            for (int i = 0; i < 16; i++) begin
                if (((i >> l) & 1) == 1) begin
                    j     = ((i >> l) << l) - 1;
                    gn[i] = gg[i] | (pp[i] & gg[j]);
                    pn[i] = pp[i] & pp[j];
                end
            end
            gg = gn;
            pp = pn;
        end
        sum_o     = '0;
        sum_o[0]  = p0[0] ^ cin_i;
        for (int i = 1; i < 16; i++) begin
            sum_o[i] = p0[i] ^ gg[i-1];
        end
        sum_o[16] = gg[15];
    end
endmodule

module lf_adder_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_chain,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic [NREQ-1:0]      ack,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [16:0]          rsp_sum,
    output logic [IDW-1:0]       rsp_id,
    output logic                 locked,
    output logic [IDW-1:0]       lock_owner
`ifdef LF_ARB_STATS_EN
    ,
    input  logic [IDW-1:0]       stat_sel,
    output logic [15:0]          stat_count
`endif
);
    typedef enum logic [0:0] {
        S_UNLOCKED = 1'b0,
        S_LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t     state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [15:0]     a_q, b_q;
    logic            cin_q;
    logic [IDW-1:0]  id_q;
    logic            valid_q;

    logic [NREQ-1:0] eligible;
    logic [IDW-1:0]  win;
    logic            any_elig;
    logic            accept;
    logic [15:0]     a_sel, b_sel;
    logic [16:0]     add_sum;
    logic            carry_q;

    // The operand register doubles as the result buffer: the adder output is
    // stable whenever the operands are held.
    Ladner_Fischer_Exact u_adder (
        .a_i   (a_q),
        .b_i   (b_q),
        .cin_i (cin_q),
        .sum_o (add_sum)
    );

    // Carry-out of the most recently accepted op. The operands of that op
    // stay registered until the next accept, so no separate flop is needed.
    assign carry_q = add_sum[16];

    // Eligibility mask, rotating priority search from rr_q, and operand mux.
    always_comb begin
        int idx;
        eligible = req;
        if (state_q == S_LOCKED) begin
            eligible = '0;
            eligible[owner_q] = req[owner_q];
        end
        win      = '0;
        any_elig = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_elig && eligible[idx]) begin
                any_elig = 1'b1;
                win      = IDW'(idx);
            end
        end
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                a_sel = req_a[16*i +: 16];
                b_sel = req_b[16*i +: 16];
            end
        end
        accept = (!valid_q || rsp_ready) && any_elig && !rst;
        ack    = '0;
        if (accept) ack[win] = 1'b1;
    end

    // Lock FSM next state and round-robin pointer update.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        if (accept) begin
            if (state_q == S_UNLOCKED) begin
                rr_d = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                if (req_chain[win]) begin
                    state_d = S_LOCKED;
                    owner_d = win;
                end
            end else if (!req_chain[win]) begin
                state_d = S_UNLOCKED;
                owner_d = '0;
            end
        end
    end

    // State, pointer and operand/result-buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_UNLOCKED;
            owner_q <= '0;
            rr_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            if (accept) begin
                a_q     <= a_sel;
                b_q     <= b_sel;
                cin_q   <= (state_q == S_LOCKED) ? carry_q : req_cin[win];
                id_q    <= win;
                valid_q <= 1'b1;
            end else if (rsp_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid  = valid_q;
    assign rsp_sum    = add_sum;
    assign rsp_id     = id_q;
    assign locked     = (state_q == S_LOCKED);
    assign lock_owner = owner_q;

`ifdef LF_ARB_STATS_EN
    logic [15:0] cnt_q [NREQ];

    // Saturating per-requester grant counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i] && (cnt_q[i] != 16'hFFFF)) cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    // Counter readback; out-of-range selects return zero.
    always_comb begin
        stat_count = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (stat_sel == IDW'(i)) stat_count = cnt_q[i];
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_lf_adder_share_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lf_adder_share_arb                                        |
// | Description : Directed scoreboard bench for lf_adder_share_arb.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lf_adder_share_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     req_chain;
    logic [NREQ*16-1:0]  req_a;
    logic [NREQ*16-1:0]  req_b;
    logic [NREQ-1:0]     req_cin;
    logic [NREQ-1:0]     ack;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [16:0]         rsp_sum;
    logic [IDW-1:0]      rsp_id;
    logic                locked;
    logic [IDW-1:0]      lock_owner;
`ifdef LF_ARB_STATS_EN
    logic [IDW-1:0]      stat_sel;
    logic [15:0]         stat_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [18:0] sb [$];

    lf_adder_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_chain  (req_chain),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .ack        (ack),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_id     (rsp_id),
        .locked     (locked),
        .lock_owner (lock_owner)
`ifdef LF_ARB_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_count (stat_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic chain);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_cin[i]        = cin;
        req_chain[i]      = chain;
    endtask

    // Check the grant vector and queue the result it must produce next cycle.
    task automatic expect_ack(input string name, input int id, input logic [16:0] sum);
        logic [3:0] exp;
        exp = 4'b0001 << id;
        chk(name, {28'b0, ack}, {28'b0, exp});
        sb.push_back({IDW'(id), sum});
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every accepted response is compared against the queue head.
    always @(negedge clk) begin
        logic [18:0] e;
        if (!rst && rsp_valid && rsp_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got id=%0d sum=0x%0h with empty queue", rsp_id, rsp_sum);
            end else begin
                e = sb.pop_front();
                if ({rsp_id, rsp_sum} !== e) begin
                    n_fail++;
                    $display("FAIL rsp_data: got id=%0d sum=0x%0h expected id=%0d sum=0x%0h",
                             rsp_id, rsp_sum, e[18:17], e[16:0]);
                end
            end
        end
    end

    int   rr_ids [5]  = '{0, 1, 2, 3, 0};
    logic [16:0] rr_sums [4] = '{17'h00004, 17'h05556, 17'h10001, 17'h10002};

    initial begin
        req = '0; req_chain = '0; req_a = '0; req_b = '0; req_cin = '0;
        rsp_ready = 1'b1;
`ifdef LF_ARB_STATS_EN
        stat_sel = '0;
`endif
        do_reset();
        #1;
        chk("reset_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_sum", {15'b0, rsp_sum}, 32'd0);
        chk("reset_id", {30'b0, rsp_id}, 32'd0);
        chk("reset_locked", {31'b0, locked}, 32'd0);
        chk("reset_owner", {30'b0, lock_owner}, 32'd0);
        chk("reset_ack", {28'b0, ack}, 32'd0);

        // Single op: 0xFFFF + 0x0001 carries out.
        set_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        req = 4'b0001;
        #1;
        expect_ack("single_ack", 0, 17'h10000);
        tick();
        req = '0;
        #1;
        chk("single_valid", {31'b0, rsp_valid}, 32'd1);
        chk("single_ack_drop", {28'b0, ack}, 32'd0);
        tick();
        chk("single_valid_clear", {31'b0, rsp_valid}, 32'd0);

        // Round robin from a fresh pointer, full throughput.
        do_reset();
        set_op(0, 16'h0001, 16'h0002, 1'b1, 1'b0);
        set_op(1, 16'h1234, 16'h4321, 1'b1, 1'b0);
        set_op(2, 16'h8000, 16'h8000, 1'b1, 1'b0);
        set_op(3, 16'hFFFF, 16'h0002, 1'b1, 1'b0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            expect_ack("rr_ack", rr_ids[k], rr_sums[rr_ids[k]]);
            if (k > 0) chk("rr_valid", {31'b0, rsp_valid}, 32'd1);
            tick();
        end
        req = '0;
        tick();

        // Backpressure: a result for req 1 is held while req 2 waits.
        set_op(1, 16'h00AA, 16'h0055, 1'b0, 1'b0);
        set_op(2, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
        req = 4'b0010;
        #1;
        expect_ack("bp_first_ack", 1, 17'h000FF);
        tick();
        rsp_ready = 1'b0;
        req = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_no_ack", {28'b0, ack}, 32'd0);
            chk("bp_sum_hold", {15'b0, rsp_sum}, 32'h000FF);
            chk("bp_id_hold", {30'b0, rsp_id}, 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        expect_ack("bp_release_ack", 2, 17'h0FFFF);
        tick();
        req = '0;
        tick();

        // 32-bit chain owned by req 1; req 0 must wait for the final word.
        set_op(1, 16'hFFFF, 16'h0002, 1'b0, 1'b1);
        set_op(0, 16'h0003, 16'h0004, 1'b0, 1'b0);
        req = 4'b0010;
        #1;
        expect_ack("chain_w0_ack", 1, 17'h10001);
        tick();
        req = 4'b0001;
        #1;
        chk("chain_locked", {31'b0, locked}, 32'd1);
        chk("chain_owner", {30'b0, lock_owner}, 32'd1);
        chk("chain_blocked", {28'b0, ack}, 32'd0);
        tick();
        chk("chain_still_locked", {31'b0, locked}, 32'd1);
        set_op(1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        req = 4'b0011;
        #1;
        expect_ack("chain_w1_ack", 1, 17'h00001);
        tick();
        req = 4'b0001;
        #1;
        chk("chain_unlocked", {31'b0, locked}, 32'd0);
        chk("chain_owner_clear", {30'b0, lock_owner}, 32'd0);
        expect_ack("chain_other_ack", 0, 17'h00007);
        tick();
        req = '0;
        tick();

        // Reset while a locked result is held under backpressure.
        rsp_ready = 1'b0;
        set_op(2, 16'h0001, 16'h0001, 1'b0, 1'b1);
        req = 4'b0100;
        #1;
        chk("rst_setup_ack", {28'b0, ack}, 32'b0100);
        tick();
        chk("rst_setup_locked", {31'b0, locked}, 32'd1);
        chk("rst_setup_valid", {31'b0, rsp_valid}, 32'd1);
        rst = 1'b1;
        set_op(2, 16'h0001, 16'h0001, 1'b0, 1'b0);
        req = 4'b0101;
        #1;
        chk("rst_cycle_ack", {28'b0, ack}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_mid_locked", {31'b0, locked}, 32'd0);
        chk("rst_mid_owner", {30'b0, lock_owner}, 32'd0);
        chk("rst_mid_sum", {15'b0, rsp_sum}, 32'd0);
        chk("rst_mid_id", {30'b0, rsp_id}, 32'd0);
        rsp_ready = 1'b1;
        #1;
        expect_ack("rst_first_grant", 0, 17'h00007);
        tick();
        req = '0;
        tick();

`ifdef LF_ARB_STATS_EN
        do_reset();
        set_op(3, 16'hFFFF, 16'h0002, 1'b1, 1'b0);
        req = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            #1;
            expect_ack("stat_ack", 3, 17'h10002);
            tick();
        end
        req = '0;
        stat_sel = 2'd3;
        #1;
        chk("stat_count5", {16'b0, stat_count}, 32'd5);
        req = 4'b1000;
        for (int k = 0; k < 65530; k++) begin
            #1;
            sb.push_back({2'd3, 17'h10002});
            tick();
        end
        req = '0;
        #1;
        chk("stat_count_max", {16'b0, stat_count}, 32'h0000FFFF);
        req = 4'b1000;
        #1;
        expect_ack("stat_sat_ack", 3, 17'h10002);
        tick();
        req = '0;
        #1;
        chk("stat_count_sat", {16'b0, stat_count}, 32'h0000FFFF);
        tick();
`endif

        // Drain: all queued results must have been observed.
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lf_adder_share_arb.md
Name: lf_adder_share_arb

Overview:
- Shares one exact 16-bit Ladner-Fischer prefix adder (`Ladner_Fischer_Exact`, instantiated internally) among NREQ requesters.
- Round-robin arbitration, registered operand stage, single-entry result buffer with valid/ready backpressure.
- Supports multi-word chained additions: the owner locks the adder and its carry-out feeds the next word's carry-in.
- Sits between requesting accumulator/MAC engines and the shared adder datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester-id width; must equal clog2(NREQ).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester operation request; held until acked.
- req_chain  in  NREQ  op is a non-final word of a chained add; lock adder after it.
- req_a  in  NREQ*16  operand A; requester i uses bits [16i+15:16i].
- req_b  in  NREQ*16  operand B, same packing.
- req_cin  in  NREQ  carry-in; used only when the op is not a chained continuation.
- ack  out  NREQ  one-hot, combinational; operands are captured at this clock edge.
- rsp_valid  out  1  result buffer full.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  17  A+B+cin; bit 16 is the carry-out.
- rsp_id  out  IDW  requester that owns rsp_sum.
- locked  out  1  chain lock active.
- lock_owner  out  IDW  id holding the lock; 0 when unlocked.

Behaviour:
- Reset outputs: rsp_valid=0, rsp_sum=0, rsp_id=0, locked=0, lock_owner=0, ack=0. Internal reset: rr_ptr=0, carry_q=0.
- Accept condition: accept = (!rsp_valid || rsp_ready) && (any eligible req).
  - Unlocked: eligible = req.
  - Locked: eligible = req & onehot(lock_owner). All other requesters are blocked.
- Round-robin arbitration:
  - Search starts at rr_ptr and wraps modulo NREQ; the first eligible index wins.
  - On a grant to i, rr_ptr <= (i+1) mod NREQ.
  - rr_ptr does not change while locked.
- Grant cycle:
  - ack[win]=1 for that single cycle only.
  - Operands are registered at the edge.
  - The adder operates on the registered operands.
- Carry-in: cin_eff = carry_q when locked (continuation word); otherwise req_cin[win].
- Latency: rsp_valid rises exactly 1 cycle after the ack cycle, with rsp_sum = {carry, sum} from the adder and rsp_id = win.
- Throughput: 1 op/cycle when rsp_ready is held high. A result is popped and a new op accepted in the same cycle (flow-through).
- Backpressure: while rsp_valid=1 and rsp_ready=0, rsp_sum and rsp_id are held stable, ack stays 0, and the operand register is unchanged.
- carry_q: loaded with adder bit 16 on each accepted op. It is used only for the next locked op.
- Lock FSM:
  - UNLOCKED --(accept with req_chain[win]=1)--> LOCKED, lock_owner=win.
  - LOCKED --(accept of owner with req_chain=1)--> LOCKED.
  - LOCKED --(accept of owner with req_chain=0, i.e. final word)--> UNLOCKED. The final word still uses carry_q.
  - If the owner deasserts req while LOCKED, the lock is held indefinitely. The requester must finish the chain; no timeout.
- Width rules: the 17-bit result is never truncated. req_a/req_b are unsigned.
- rst asserted mid-operation: next edge clears the buffer (pending result lost), the lock, rr_ptr and carry_q. No ack is issued in the reset cycle.

Optional Feature:
- Macro: LF_ARB_STATS_EN.
- Defined:
  - Adds ports stat_sel (in, IDW) and stat_count (out, 16).
  - Adds a per-requester 16-bit grant counter: increments on each ack, saturates at 0xFFFF, cleared by rst.
  - stat_count = counter[stat_sel], combinational.
- Undefined: no counters and no stat ports. All other behaviour is identical.

Test Plan:
- Single op: req[0] with A=0xFFFF, B=0x0001, cin=0 -> ack[0] in cycle t; rsp_valid at t+1 with rsp_sum=0x10000, rsp_id=0.
- Round-robin: req=4'b1111 held, rsp_ready=1 -> acks in order 0,1,2,3,0, one per cycle; rsp_valid continuously high from the second cycle.
- Backpressure: rsp_ready=0 for 3 cycles with req[2] pending -> rsp_sum and rsp_id stable, no ack. rsp_ready=1 -> pop and ack[2] in the same cycle.
- 32-bit chain by req 1:
  - Word 0: A=0xFFFF, B=0x0002, chain=1 -> rsp_sum=0x10001, locked=1, lock_owner=1.
  - req[0] asserted meanwhile -> not acked.
  - Word 1: A=0x0000, B=0x0000, chain=0, req_cin=0 -> rsp_sum=0x00001 (carry_q used), then locked=0 and req 0 is acked next.
- Reset mid-op: rst during a held rsp_valid=1 with locked=1 -> next cycle all outputs at reset values; the first post-reset grant goes to the lowest requesting index.
- LF_ARB_STATS_EN: 5 grants to req 3 -> stat_sel=3 gives stat_count=5. Force a counter to 0xFFFF, grant once more -> stays 0xFFFF.
